// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - state encoding and counter sizing shared by the PLL clock-enable sequencer
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    ENABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } pll_state_e;

  // Width needed for a counter that must be able to hold max_val itself
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer, async active-low reset to 0
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_clken_sequencer.sv
// rtl/pll_clken_sequencer.sv - PLL reset, lock qualification, staggered clock enables and system reset release
// Optional retry limit with FAIL state and sticky lock_fail: define PLL_SEQ_RETRY_LIMIT_EN
module pll_clken_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_CLK          = 5,
  parameter int RST_HOLD_CYC     = 64,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STAGGER_CYC      = 16
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  ,
  parameter int MAX_RETRY        = 3
`endif
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic [NUM_CLK-1:0] enclk,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               lock_fail,
  output logic [STATE_W-1:0] state_o
);

  localparam int HOLD_W    = cnt_w(RST_HOLD_CYC);
  localparam int STAB_W    = cnt_w(LOCK_STABLE_CYC);
  localparam int TMO_W     = cnt_w(LOCK_TIMEOUT_CYC);
  localparam int PH_W      = cnt_w(NUM_CLK * STAGGER_CYC);
  localparam int LAST_RISE = (NUM_CLK - 1) * STAGGER_CYC;

  logic               lock_s;
  pll_state_e         state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [STAB_W-1:0]  stable_q, stable_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [PH_W-1:0]    phase_q, phase_d, phase_inc;
  logic               stable_hit, tmo_hit, retry_exhausted;
  logic               pll_reset_q, pll_reset_d;
  logic [NUM_CLK-1:0] enclk_q, enclk_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;

  sync_2ff u_lock_sync (
    .clk_i   (clkin),
    .rst_n_i (rst_n),
    .d_i     (pll_lock),
    .q_o     (lock_s)
  );

  assign phase_inc  = (phase_q == '1) ? phase_q : phase_q + 1'b1;
  assign stable_hit = lock_s && (stable_q >= STAB_W'(LOCK_STABLE_CYC - 1));
  assign tmo_hit    = tmo_q >= TMO_W'(LOCK_TIMEOUT_CYC - 1);

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam int RETRY_W = cnt_w(MAX_RETRY);

  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               lock_fail_q, lock_fail_d;

  assign retry_inc       = (retry_q == '1) ? retry_q : retry_q + 1'b1;
  assign retry_exhausted = retry_inc >= RETRY_W'(MAX_RETRY);

  // Count abandoned attempts, forget them once RUN is reached; latch failure
  always_comb begin
    retry_d = retry_q;
    if (state_q == WAIT_LOCK && tmo_hit && !stable_hit) retry_d = retry_inc;
    if (state_d == RUN && state_q != RUN) retry_d = '0;
    lock_fail_d = lock_fail_q || (state_d == FAIL);
  end

  // Retry counter and sticky failure flag registers
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      retry_q     <= '0;
      lock_fail_q <= 1'b0;
    end else begin
      retry_q     <= retry_d;
      lock_fail_q <= lock_fail_d;
    end
  end

  assign lock_fail = lock_fail_q;
`else
  assign retry_exhausted = 1'b0;
  assign lock_fail       = 1'b0;
`endif

  // State, counters and registered outputs
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      hold_q      <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      phase_q     <= '0;
      pll_reset_q <= 1'b1;
      enclk_q     <= '0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      phase_q     <= phase_d;
      pll_reset_q <= pll_reset_d;
      enclk_q     <= enclk_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

  // Next state: any lock loss after qualification restarts the whole bring-up
  always_comb begin
    state_d = state_q;
    case (state_q)
      PLL_RST:   if (hold_q >= HOLD_W'(RST_HOLD_CYC - 1)) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (stable_hit)   state_d = ENABLE;
        else if (tmo_hit) state_d = retry_exhausted ? FAIL : PLL_RST;
      end
      ENABLE: begin
        if (!lock_s)                               state_d = PLL_RST;
        else if (phase_inc >= PH_W'(LAST_RISE))    state_d = RELEASE;
      end
      RELEASE: begin
        if (!lock_s)                               state_d = PLL_RST;
        else if (phase_inc >= PH_W'(STAGGER_CYC))  state_d = RUN;
      end
      RUN:     if (!lock_s) state_d = PLL_RST;
      FAIL:    state_d = FAIL;
      default: state_d = PLL_RST;
    endcase
  end

  // Counters run only while the state is held and restart from 0 on every entry
  always_comb begin
    hold_d   = '0;
    stable_d = '0;
    tmo_d    = '0;
    phase_d  = '0;
    if (state_q == PLL_RST && state_d == PLL_RST)
      hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
    if (state_q == WAIT_LOCK && state_d == WAIT_LOCK) begin
      tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
      if (lock_s) stable_d = (stable_q == '1) ? stable_q : stable_q + 1'b1;
    end
    if (state_q == state_d && (state_q == ENABLE || state_q == RELEASE))
      phase_d = phase_inc;
  end

  // Outputs follow the state being entered so they change on the same edge
  always_comb begin
    pll_reset_d = (state_d == PLL_RST) || (state_d == FAIL);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    enclk_d     = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      if (state_d == RELEASE || state_d == RUN) enclk_d[i] = 1'b1;
      else if (state_d == ENABLE)               enclk_d[i] = phase_d >= PH_W'(i * STAGGER_CYC);
    end
  end

  assign pll_reset = pll_reset_q;
  assign enclk     = enclk_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_clken_sequencer.sv
// tb/tb_pll_clken_sequencer.sv - self-checking bench for pll_clken_sequencer
module tb_pll_clken_sequencer;

  localparam int NCLK   = 5;
  localparam int HOLD   = 4;
  localparam int STABLE = 8;
  localparam int TMO    = 32;
  localparam int STAG   = 4;
  localparam int MAXR   = 2;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic            clkin = 1'b0;
  logic            rst_n;
  logic            pll_lock = 1'b0;
  logic            pll_reset;
  logic [NCLK-1:0] enclk;
  logic            sys_rst_n;
  logic            ready;
  logic            lock_fail;
  logic [2:0]      state_o;

  int checks   = 0;
  int failures = 0;
  int tcyc     = 0;

  always #5 clkin = ~clkin;

  pll_clken_sequencer #(
    .NUM_CLK          (NCLK),
    .RST_HOLD_CYC     (HOLD),
    .LOCK_STABLE_CYC  (STABLE),
    .LOCK_TIMEOUT_CYC (TMO),
    .STAGGER_CYC      (STAG)
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    ,
    .MAX_RETRY        (MAXR)
`endif
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .enclk     (enclk),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .lock_fail (lock_fail),
    .state_o   (state_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: timestamps of the current attempt and of clock enabling
  int              cyc, rst_t0, en_t0, stable, retries;
  bit              failed, lk1, lk2, lock_s;
  logic            e_rst, e_sys, e_rdy, e_lf;
  logic [NCLK-1:0] e_en;

  always @(negedge clkin) begin
    if (!rst_n) begin
      check("rst_pll_reset", 32'(pll_reset), 1);
      check("rst_enclk",     32'(enclk),     0);
      check("rst_sys_rst_n", 32'(sys_rst_n), 0);
      check("rst_ready",     32'(ready),     0);
      check("rst_lock_fail", 32'(lock_fail), 0);
      cyc = 0; rst_t0 = 0; en_t0 = -1; stable = 0; retries = 0;
      failed = 1'b0; lk1 = 1'b0; lk2 = 1'b0;
    end else begin
      if (failed) begin
        e_rst = 1'b1; e_en = '0; e_sys = 1'b0; e_rdy = 1'b0; e_lf = 1'b1;
      end else if (en_t0 < 0) begin
        e_rst = (cyc - rst_t0) < HOLD; e_en = '0; e_sys = 1'b0; e_rdy = 1'b0; e_lf = 1'b0;
      end else begin
        e_rst = 1'b0; e_lf = 1'b0;
        for (int i = 0; i < NCLK; i++) e_en[i] = (cyc - en_t0) >= i * STAG;
        e_sys = (cyc - en_t0) >= NCLK * STAG;
        e_rdy = e_sys;
      end
      check("model_pll_reset", 32'(pll_reset), 32'(e_rst));
      check("model_enclk",     32'(enclk),     32'(e_en));
      check("model_sys_rst_n", 32'(sys_rst_n), 32'(e_sys));
      check("model_ready",     32'(ready),     32'(e_rdy));
      check("model_lock_fail", 32'(lock_fail), 32'(e_lf));
      lock_s = lk2;
      if (!failed) begin
        if (en_t0 >= 0) begin
          if (!lock_s) begin
            rst_t0 = cyc + 1; en_t0 = -1; stable = 0;
          end else if (cyc + 1 - en_t0 == NCLK * STAG) begin
            retries = 0;
          end
        end else if (cyc - rst_t0 >= HOLD) begin
          stable = lock_s ? stable + 1 : 0;
          if (stable == STABLE) begin
            en_t0 = cyc + 1;
          end else if (cyc - rst_t0 - HOLD == TMO - 1) begin
            retries++; stable = 0;
            if (LIMIT && retries >= MAXR) failed = 1'b1;
            else rst_t0 = cyc + 1;
          end
        end
      end
      lk2 = lk1; lk1 = pll_lock; cyc++;
    end
  end

  task automatic goto(input int k);
    if (tcyc < k) begin
      while (tcyc < k) begin
        @(posedge clkin);
        tcyc++;
      end
      #2;
    end
  endtask

  task automatic release_reset();
    @(posedge clkin);
    #2;
    rst_n = 1'b1;
    tcyc  = 0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clkin);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clkin);
    #2;
    check("lit_reset_pll_reset", 32'(pll_reset), 1);
    check("lit_reset_state",     32'(state_o),   0);

    // Nominal bring-up, then lock loss in RUN and full re-run
    release_reset();
    goto(3);  check("t1_pll_reset_c3", 32'(pll_reset), 1);
    goto(4);  check("t1_pll_reset_c4", 32'(pll_reset), 0);
              check("t1_state_c4",     32'(state_o),   1);
    goto(10); pll_lock = 1'b1;
    goto(19); check("t1_enclk_c19", 32'(enclk), 0);
    goto(20); check("t1_enclk_c20", 32'(enclk), 5'b00001);
              check("t1_state_c20", 32'(state_o), 2);
    goto(24); check("t1_enclk_c24", 32'(enclk), 5'b00011);
    goto(28); check("t1_enclk_c28", 32'(enclk), 5'b00111);
    goto(32); check("t1_enclk_c32", 32'(enclk), 5'b01111);
    goto(36); check("t1_enclk_c36", 32'(enclk), 5'b11111);
    goto(39); check("t1_sys_rst_n_c39", 32'(sys_rst_n), 0);
    goto(40); check("t1_sys_rst_n_c40", 32'(sys_rst_n), 1);
              check("t1_ready_c40",     32'(ready),     1);
              check("t1_state_c40",     32'(state_o),   4);
    goto(50); pll_lock = 1'b0;
    goto(52); check("t3_ready_c52",     32'(ready),     1);
    goto(53); check("t3_enclk_c53",     32'(enclk),     0);
              check("t3_sys_rst_n_c53", 32'(sys_rst_n), 0);
              check("t3_ready_c53",     32'(ready),     0);
              check("t3_pll_reset_c53", 32'(pll_reset), 1);
    goto(55); pll_lock = 1'b1;
    goto(57); check("t3_pll_reset_c57", 32'(pll_reset), 0);
    goto(64); check("t3_enclk_c64", 32'(enclk), 0);
    goto(65); check("t3_enclk_c65", 32'(enclk), 5'b00001);
    goto(85); check("t3_ready_c85", 32'(ready), 1);
              check("t3_lock_fail_c85", 32'(lock_fail), 0);

    // Lock glitch during WAIT_LOCK, then asynchronous reset mid-enable
    goto(87);
    assert_reset();
    release_reset();
    goto(7);  pll_lock = 1'b0;
    goto(8);  pll_lock = 1'b1;
    goto(12); check("t2_enclk_c12", 32'(enclk), 0);
    goto(17); check("t2_enclk_c17", 32'(enclk), 0);
    goto(18); check("t2_enclk_c18", 32'(enclk), 5'b00001);
    goto(26); check("t5_enclk_before", 32'(enclk), 5'b00111);
    rst_n = 1'b0;
    #1;
    check("t5_enclk_async",     32'(enclk),     0);
    check("t5_pll_reset_async", 32'(pll_reset), 1);
    check("t5_sys_rst_n_async", 32'(sys_rst_n), 0);
    check("t5_lock_fail_async", 32'(lock_fail), 0);
    repeat (2) @(posedge clkin);
    release_reset();
    goto(3);  check("t5_pll_reset_c3", 32'(pll_reset), 1);
    goto(4);  check("t5_pll_reset_c4", 32'(pll_reset), 0);
    goto(11); check("t5_enclk_c11", 32'(enclk), 0);
    goto(12); check("t5_enclk_c12", 32'(enclk), 5'b00001);

    // Lock never arrives: timeouts and, with the limit built, FAIL
    goto(14);
    pll_lock = 1'b0;
    assert_reset();
    release_reset();
    goto(3);  check("t4_pll_reset_c3",  32'(pll_reset), 1);
    goto(4);  check("t4_pll_reset_c4",  32'(pll_reset), 0);
    goto(35); check("t4_pll_reset_c35", 32'(pll_reset), 0);
    goto(36); check("t4_pll_reset_c36", 32'(pll_reset), 1);
    goto(39); check("t4_pll_reset_c39", 32'(pll_reset), 1);
    goto(40); check("t4_pll_reset_c40", 32'(pll_reset), 0);
    goto(71); check("t4_pll_reset_c71", 32'(pll_reset), 0);
    goto(72); check("t4_pll_reset_c72", 32'(pll_reset), 1);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
              check("t4_lock_fail_c72", 32'(lock_fail), 1);
              check("t4_state_c72",     32'(state_o),   5);
    goto(110); check("t4_pll_reset_c110", 32'(pll_reset), 1);
               check("t4_lock_fail_c110", 32'(lock_fail), 1);
               check("t4_enclk_c110",     32'(enclk),     0);
`else
              check("t4_lock_fail_c72", 32'(lock_fail), 0);
    goto(75); check("t4_pll_reset_c75", 32'(pll_reset), 1);
    goto(76); check("t4_pll_reset_c76", 32'(pll_reset), 0);
    goto(108); check("t4_pll_reset_c108", 32'(pll_reset), 1);
    goto(110); check("t4_lock_fail_c110", 32'(lock_fail), 0);
`endif
    goto(115);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
